// File: rtl/ar_pkg.sv
// Shared definitions for the two-wire return-to-zero word link (both directions).
// Latency: n/a (constants, types and a parity helper only).
// Backpressure: n/a.
package ar_pkg;

  localparam int AR_WORD_BITS    = 32;
  localparam int AR_ADR_BITS     = 8;
  localparam int AR_DAT_BITS     = 23;
  // Receiver idle time (clk) after which it resynchronises to a word start.
  localparam int AR_RX_THRESHOLD = 3001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } ar_state_t;

  // Odd parity: makes the total count of ones over the 32-bit word odd.
  function automatic logic ar_parity(input logic [AR_ADR_BITS-1:0] adr,
                                     input logic [AR_DAT_BITS-1:0] dat);
    return ~^{adr, dat};
  endfunction

endpackage

// File: rtl/ar_bit_timer.sv
// Bit-period timer: cb_tact counts 0..BIT_DIV-1, flags the first half and the last tick.
// Latency: combinational flags from the registered count.
// Backpressure: none; clr holds the count at zero.
module ar_bit_timer #(
  parameter int BIT_DIV = 500
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  output logic [$clog2(BIT_DIV)-1:0] cb_tact,
  output logic                       half_phase,
  output logic                       bit_end
);

  localparam int TW = $clog2(BIT_DIV);
  localparam logic [TW-1:0] TACT_LAST = TW'(BIT_DIV - 1);
  localparam logic [TW-1:0] TACT_HALF = TW'(BIT_DIV / 2);

  // Free-running modulo-BIT_DIV count, held at zero while cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cb_tact <= '0;
    end else if (clr || bit_end) begin
      cb_tact <= '0;
    end else begin
      cb_tact <= cb_tact + 1'b1;
    end
  end

  assign half_phase = (cb_tact < TACT_HALF);
  assign bit_end    = (cb_tact == TACT_LAST);

endmodule

// File: rtl/ar_txd.sv
// Two-wire RZ word transmitter: 8-bit address, 23-bit data (LSB first), odd parity.
// Latency: lines and en_tx go active 1 clk after an accepted st; word period 32*BIT_DIV + GAP_BITS*BIT_DIV.
// Backpressure: st is only sampled in IDLE; requests while en_tx is high are dropped.
module ar_txd
  import ar_pkg::*;
#(
  parameter int BIT_DIV  = 500,
  parameter int GAP_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st,
  input  logic [7:0]  adr,
  input  logic [22:0] dat,
  output logic        TXD1,
  output logic        TXD0,
  output logic        en_tx,
  output logic        ce_done,
  output logic [4:0]  cb_bit
);

  localparam int TW = $clog2(BIT_DIV);
  localparam int GW = $clog2(GAP_BITS + 1);
  localparam logic [4:0]    LAST_BIT = 5'(AR_WORD_BITS - 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(BIT_DIV / 2 - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

  ar_state_t                state, state_nxt;
  logic [AR_WORD_BITS-1:0]  sr, sr_nxt, word_in;
  logic [AR_DAT_BITS-1:0]   dat_rev;
  logic [4:0]               cb_bit_nxt;
  logic [TW-1:0]            cb_tact;
  logic [GW-1:0]            gcnt;
  logic                     half_phase, bit_end, gap_last, line_on, tmr_clr;

  // The timer sits at zero in IDLE so the first bit starts with a full period.
  assign tmr_clr = (state == IDLE);

  ar_bit_timer #(.BIT_DIV(BIT_DIV)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (tmr_clr),
    .cb_tact   (cb_tact),
    .half_phase(half_phase),
    .bit_end   (bit_end)
  );

  // The gap counts whole bit periods on the shared timer.
  assign gap_last = bit_end && (gcnt == GAP_LAST);

  // Data goes out LSB first, so it is stored bit-reversed behind the address.
  always_comb begin
    dat_rev = '0;
    for (int i = 0; i < AR_DAT_BITS; i++) begin
      dat_rev[i] = dat[AR_DAT_BITS-1-i];
    end
  end

  assign word_in = {adr, dat_rev, ar_parity(adr, dat)};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (st) state_nxt = SEND;
      SEND:    if (bit_end && (cb_bit == LAST_BIT)) state_nxt = GAP;
      GAP:     if (gap_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; line_on is the half-phase of the *next* cycle so the lines can be registered.
  always_comb begin
    en_tx   = (state != IDLE);
    ce_done = (state == GAP) && gap_last;
    line_on = (state_nxt == SEND) &&
              ((state == IDLE) || bit_end || (half_phase && (cb_tact != HALF_M1)));
  end

  // Shift register and bit index: load on accept, advance at each bit boundary except after bit 31.
  always_comb begin
    sr_nxt     = sr;
    cb_bit_nxt = cb_bit;
    if ((state == IDLE) && st) begin
      sr_nxt     = word_in;
      cb_bit_nxt = '0;
    end else if ((state == SEND) && bit_end && (cb_bit != LAST_BIT)) begin
      sr_nxt     = sr << 1;
      cb_bit_nxt = cb_bit + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      cb_bit <= '0;
    end else begin
      sr     <= sr_nxt;
      cb_bit <= cb_bit_nxt;
    end
  end

  // Gap length counter, idle outside GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= '0;
    end else if (state != GAP) begin
      gcnt <= '0;
    end else if (bit_end) begin
      gcnt <= gcnt + 1'b1;
    end
  end

  // Registered line drivers: current bit on one line during the first half, both null otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TXD1 <= 1'b0;
      TXD0 <= 1'b0;
    end else begin
      TXD1 <= line_on &  sr_nxt[AR_WORD_BITS-1];
      TXD0 <= line_on & ~sr_nxt[AR_WORD_BITS-1];
    end
  end

endmodule

// File: tb/tb_ar_txd.sv
// Self-checking bench for ar_txd: cycle-accurate reference model plus a line decoder
// that pops expected words from a scoreboard queue filled when requests are accepted.
module tb_ar_txd;

  localparam int BD       = 8;
  localparam int GB       = 4;
  localparam int SEND_CYC = 32 * BD;
  localparam int WORD_CYC = SEND_CYC + GB * BD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        st    = 1'b0;
  logic [7:0]  adr   = '0;
  logic [22:0] dat   = '0;
  logic        TXD1, TXD0, en_tx, ce_done;
  logic [4:0]  cb_bit;

  int n_total = 0;
  int n_bad   = 0;

  ar_txd #(.BIT_DIV(BD), .GAP_BITS(GB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .st     (st),
    .adr    (adr),
    .dat    (dat),
    .TXD1   (TXD1),
    .TXD0   (TXD0),
    .en_tx  (en_tx),
    .ce_done(ce_done),
    .cb_bit (cb_bit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected word, bit k of the transmission at position [31-k].
  function automatic logic [31:0] exp_word(input logic [7:0] a, input logic [22:0] d);
    logic [31:0] w;
    int ones;
    w = '0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      w[31-i] = a[7-i];
      ones += int'(a[i]);
    end
    for (int i = 0; i < 23; i++) begin
      w[23-i] = d[i];
      ones += int'(d[i]);
    end
    w[0] = ((ones % 2) == 0);
    return w;
  endfunction

  // Reference model: acceptance timing and the scoreboard of expected words.
  logic [31:0] sb_q[$];
  bit          m_act     = 1'b0;
  int          cyc       = 0;
  int          acc       = 0;
  logic [31:0] m_word    = '0;
  logic [4:0]  m_cb_idle = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act     = 1'b0;
      m_cb_idle = '0;
      sb_q.delete();
    end else begin
      cyc++;
      if (!m_act && st) begin
        m_act  = 1'b1;
        acc    = cyc;
        m_word = exp_word(adr, dat);
        sb_q.push_back(m_word);
      end else if (m_act && (cyc - acc >= WORD_CYC)) begin
        m_act     = 1'b0;
        m_cb_idle = 5'd31;
      end
    end
  end

  // Per-cycle output check and line decoder, sampled on the falling edge.
  logic        or_prev   = 1'b0;
  logic [31:0] rx_bits   = '0;
  int          nbits     = 0;
  logic [31:0] last_word = '0;
  int          done_cnt  = 0;

  always @(negedge clk) begin
    logic       e1, e0, een, ecd;
    logic [4:0] ecb;
    int         j;
    e1 = 1'b0; e0 = 1'b0; een = 1'b0; ecd = 1'b0; ecb = m_cb_idle;
    if (m_act) begin
      j   = cyc - acc;
      een = 1'b1;
      ecd = (j == WORD_CYC - 1);
      if (j < SEND_CYC) begin
        ecb = 5'(j / BD);
        if ((j % BD) < BD / 2) begin
          e1 =  m_word[31 - j / BD];
          e0 = ~m_word[31 - j / BD];
        end
      end else begin
        ecb = 5'd31;
      end
    end
    chk("cycle", {TXD1, TXD0, en_tx, ce_done, cb_bit}, {e1, e0, een, ecd, ecb});

    if (!rst_n) begin
      nbits   = 0;
      or_prev = 1'b0;
    end else begin
      if ((TXD1 | TXD0) && !or_prev) begin
        rx_bits = {rx_bits[30:0], TXD1};
        nbits++;
        if (nbits == 32) begin
          chk("sb_nonempty", 64'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) chk("word", rx_bits, sb_q.pop_front());
          chk("parity", 64'(^rx_bits), 1);
          last_word = rx_bits;
        end
      end
      or_prev = TXD1 | TXD0;
      if (ce_done) begin
        chk("edges", nbits, 32);
        nbits = 0;
        done_cnt++;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_act && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("idle_timeout", n, 0);
  endtask

  // Single-cycle request; inputs are scrambled afterwards to show they are no longer used.
  task automatic send(input logic [7:0] a, input logic [22:0] d);
    st  = 1'b1;
    adr = a;
    dat = d;
    @(posedge clk); #1;
    st  = 1'b0;
    adr = 8'($urandom);
    dat = 23'($urandom);
  endtask

  initial begin
    int n;
    int d0;
    logic [7:0]  ra;
    logic [22:0] rd;

    // Reset values
    #1 rst_n = 1'b0;
    #1 chk("reset", {TXD1, TXD0, en_tx, ce_done, cb_bit}, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: A5/000001, latency to ce_done, busy and same-cycle-as-done requests ignored
    send(8'hA5, 23'h000001);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      st  = (n == 50) || (n == 270) || (n == 287);
      adr = 8'($urandom);
      dat = 23'($urandom);
    end while (!ce_done && n < 400);
    chk("t1_latency", n + 1, WORD_CYC);
    @(posedge clk); #1;
    st = 1'b0;
    chk("t1_idle_en", en_tx, 0);
    chk("t1_word", last_word, 32'hA580_0000);

    // 2: all-zero payload, only the parity bit on TXD1
    wait_idle();
    send(8'h00, 23'h000000);
    wait_idle();
    chk("t2_word", last_word, 32'h0000_0001);

    // 3: st held high for 1000 clk
    wait_idle();
    d0 = done_cnt;
    st = 1'b1;
    repeat (1000) begin
      adr = 8'($urandom);
      dat = 23'($urandom);
      @(posedge clk); #1;
    end
    st = 1'b0;
    chk("t3_words", done_cnt - d0, 3);
    wait_idle();

    // 4: reset at bit 12, tact 2, then a clean word
    send(8'h5A, 23'h012345);
    repeat (98) @(posedge clk);
    #2;
    chk("t4_pre", {en_tx, TXD1 | TXD0}, 2'b11);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1 chk("t4_rst", {TXD1, TXD0, en_tx, ce_done}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("t4_no_done", done_cnt - d0, 0);
    @(posedge clk); #1;
    send(8'h3C, 23'h7FFFFF);
    wait_idle();
    chk("t4_word", last_word, exp_word(8'h3C, 23'h7FFFFF));

    // 5/6: specific loopback words and a random parity sweep
    send(8'hA5, 23'h2AAAAA);
    wait_idle();
    chk("t5_word", last_word, exp_word(8'hA5, 23'h2AAAAA));
    for (int k = 0; k < 64; k++) begin
      ra = 8'($urandom);
      rd = 23'($urandom);
      send(ra, rd);
      wait_idle();
    end

    repeat (5) @(posedge clk); #1;
    chk("sb_left", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
